// File: rtl/dma_pkg.sv
// ----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the mem_copy_dma block. It provides the controller
// state encoding and the command mode constants.
// ----------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_dma.sv
// ----------------------------------------------------------------------------
// mem_copy_dma
// This block drives the single port of the data memory. It accepts one command
// and then moves or fills a byte region with no processor involvement. Copy
// mode alternates a read cycle and a write cycle for each byte. Fill mode
// writes one byte per cycle.
//
// Ports
//   i_clk, i_reset     system clock; synchronous, active-high reset
//   i_start            command strobe (sampled only in IDLE)
//   i_mode             0 = copy, 1 = fill
//   i_src, i_dst       source / destination start addresses
//   i_len              byte count (0 completes at once)
//   i_fill_val         fill byte
//   o_mem_addr         memory address
//   o_mem_dat_in       memory write data
//   o_mem_wr_en        memory write enable
//   i_mem_dat_out      combinational memory read data
//   o_busy             high in READ and WRITE (external mux select)
//   o_done             one-cycle completion pulse
// ----------------------------------------------------------------------------
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [7:0]    i_len,
    input  logic [DW-1:0] i_fill_val,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_dat_in,
    output logic          o_mem_wr_en,
    input  logic [DW-1:0] i_mem_dat_out,
    output logic          o_busy,
    output logic          o_done
);

    dma_state_e    r_state;
    dma_state_e    w_next_state;
    logic [AW-1:0] r_src_ptr;
    logic [AW-1:0] r_dst_ptr;
    logic [7:0]    r_count;
    logic          r_mode;
    logic [DW-1:0] r_data;

    // State register and datapath. The pointers wrap naturally at 2^AW.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_mode    <= MODE_COPY;
            r_data    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_src_ptr <= i_src;
                        r_dst_ptr <= i_dst;
                        r_count   <= i_len;
                        r_mode    <= i_mode;
                        // Preloading the fill byte lets fill mode skip the READ state.
                        r_data    <= i_fill_val;
                    end
                end
                READ: begin
                    r_data    <= i_mem_dat_out;
                    r_src_ptr <= r_src_ptr + 1'b1;
                end
                WRITE: begin
                    r_dst_ptr <= r_dst_ptr + 1'b1;
                    r_count   <= r_count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and memory-port decode
    always_comb begin
        w_next_state = r_state;
        o_mem_addr   = '0;
        o_mem_dat_in = '0;
        o_mem_wr_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_len == 8'd0)
                        w_next_state = DONE;
                    else if (i_mode == MODE_FILL)
                        w_next_state = WRITE;
                    else
                        w_next_state = READ;
                end
            end
            READ: begin
                o_mem_addr   = r_src_ptr;
                w_next_state = WRITE;
            end
            WRITE: begin
                o_mem_addr   = r_dst_ptr;
                o_mem_dat_in = r_data;
                // Without this gate, a reset raised during a WRITE cycle would
                // let the memory commit one more byte at the reset edge.
                o_mem_wr_en  = ~i_reset;
                if (r_count == 8'd1)
                    w_next_state = DONE;
                else if (r_mode == MODE_FILL)
                    w_next_state = WRITE;
                else
                    w_next_state = READ;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_busy = (r_state == READ) || (r_state == WRITE);
    assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_mem_copy_dma.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_dma
// Directed bench for mem_copy_dma. It models a 256 x 8 memory with a
// combinational read and a write on the clock edge. It also checks cycle
// timing and memory contents against hand-computed values.
// ----------------------------------------------------------------------------
module tb_mem_copy_dma;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic       i_mode;
    logic [7:0] i_src, i_dst, i_len, i_fill_val;
    logic [7:0] o_mem_addr, o_mem_dat_in, i_mem_dat_out;
    logic       o_mem_wr_en, o_busy, o_done;

    logic [7:0] mem [0:255];
    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mem_copy_dma #(.AW(8), .DW(8)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_src        (i_src),
        .i_dst        (i_dst),
        .i_len        (i_len),
        .i_fill_val   (i_fill_val),
        .o_mem_addr   (o_mem_addr),
        .o_mem_dat_in (o_mem_dat_in),
        .o_mem_wr_en  (o_mem_wr_en),
        .i_mem_dat_out(i_mem_dat_out),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    assign i_mem_dat_out = mem[o_mem_addr];
    always @(posedge i_clk) if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_dat_in;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command and then samples at each negedge. Cycle c is the cycle
    // after edge E(c-1). The task records the first done cycle, the number of
    // busy cycles and the number of write cycles. If inj != 0, it pulses a
    // conflicting fill command (dst 0x30) during cycle inj.
    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] f, input int inj,
                       output int dc, output int bc, output int wc);
        dc = 0; bc = 0; wc = 0;
        @(negedge i_clk);
        i_start = 1'b1; i_mode = m; i_src = s; i_dst = d; i_len = l; i_fill_val = f;
        for (int c = 1; c <= 600; c++) begin
            @(negedge i_clk);
            if (o_busy) bc++;
            if (o_mem_wr_en) wc++;
            if (o_done && dc == 0) dc = c;
            if (c == inj) begin
                i_start = 1'b1; i_mode = 1'b1; i_dst = 8'h30; i_len = 8'd2; i_fill_val = 8'h99;
            end else begin
                i_start = 1'b0;
            end
            if (dc != 0) break;
        end
        i_start = 1'b0;
    endtask

    int dc, bc, wc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        i_reset = 1'b1; i_start = 1'b0; i_mode = 1'b0;
        i_src = 8'h00; i_dst = 8'h00; i_len = 8'h00; i_fill_val = 8'h00;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_wr", o_mem_wr_en, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_dat", o_mem_dat_in, 0);
        i_reset = 1'b0;

        // Basic copy, 4 bytes
        mem[60] = 8'h10; mem[61] = 8'hE0; mem[62] = 8'hF0; mem[63] = 8'hCC;
        run(1'b0, 8'd60, 8'd100, 8'd4, 8'h00, 0, dc, bc, wc);
        chk("copy_done_cyc", dc, 9);
        chk("copy_busy_cyc", bc, 8);
        chk("copy_wr_cnt", wc, 4);
        chk("copy_m100", mem[100], 8'h10);
        chk("copy_m101", mem[101], 8'hE0);
        chk("copy_m102", mem[102], 8'hF0);
        chk("copy_m103", mem[103], 8'hCC);

        // Fill of 3 bytes. The byte after the region must stay unchanged.
        mem[203] = 8'h55;
        run(1'b1, 8'd0, 8'd200, 8'd3, 8'hAA, 0, dc, bc, wc);
        chk("fill_done_cyc", dc, 4);
        chk("fill_busy_cyc", bc, 3);
        chk("fill_m200", mem[200], 8'hAA);
        chk("fill_m201", mem[201], 8'hAA);
        chk("fill_m202", mem[202], 8'hAA);
        chk("fill_m203", mem[203], 8'h55);

        // Source address wrap
        mem[254] = 8'd1; mem[255] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
        run(1'b0, 8'd254, 8'd10, 8'd4, 8'h00, 0, dc, bc, wc);
        chk("wrap_done_cyc", dc, 9);
        chk("wrap_m10", mem[10], 1);
        chk("wrap_m11", mem[11], 2);
        chk("wrap_m12", mem[12], 3);
        chk("wrap_m13", mem[13], 4);

        // Destination wrap on fill
        run(1'b1, 8'd0, 8'd255, 8'd2, 8'h77, 0, dc, bc, wc);
        chk("fwrap_m255", mem[255], 8'h77);
        chk("fwrap_m0", mem[0], 8'h77);
        chk("fwrap_m1", mem[1], 4);
        chk("fwrap_m254", mem[254], 1);

        // Overlapping forward copy replicates the pattern
        mem[50] = 8'h5A; mem[51] = 8'h00; mem[52] = 8'h00; mem[53] = 8'h00; mem[54] = 8'h00;
        run(1'b0, 8'd50, 8'd51, 8'd3, 8'h00, 0, dc, bc, wc);
        chk("ovl_m51", mem[51], 8'h5A);
        chk("ovl_m52", mem[52], 8'h5A);
        chk("ovl_m53", mem[53], 8'h5A);
        chk("ovl_m54", mem[54], 8'h00);

        // Zero length
        run(1'b0, 8'd60, 8'd110, 8'd0, 8'h00, 0, dc, bc, wc);
        chk("len0_done_cyc", dc, 1);
        chk("len0_busy", bc, 0);
        chk("len0_wr", wc, 0);
        chk("len0_m110", mem[110], 8'h00);

        // A second start during a busy copy is ignored
        mem[8'h30] = 8'h00; mem[8'h31] = 8'h00;
        run(1'b0, 8'd60, 8'd120, 8'd4, 8'h00, 3, dc, bc, wc);
        chk("ign_done_cyc", dc, 9);
        chk("ign_wr_cnt", wc, 4);
        chk("ign_m120", mem[120], 8'h10);
        chk("ign_m123", mem[123], 8'hCC);
        chk("ign_m30", mem[8'h30], 8'h00);
        @(negedge i_clk);
        chk("ign_idle_busy", o_busy, 0);

        // Reset during the WRITE of byte 2 of a 4-byte copy
        for (int i = 0; i < 4; i++) begin
            mem[150 + i] = 8'(i + 1);
            mem[160 + i] = 8'hEE;
        end
        @(negedge i_clk);
        i_start = 1'b1; i_mode = 1'b0; i_src = 8'd150; i_dst = 8'd160; i_len = 8'd4;
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (c == 4) begin
                chk("rmid_wr_before", o_mem_wr_en, 1);
                i_reset = 1'b1;
            end
        end
        @(negedge i_clk);
        chk("rmid_wr", o_mem_wr_en, 0);
        chk("rmid_busy", o_busy, 0);
        chk("rmid_done", o_done, 0);
        i_reset = 1'b0;
        dc = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_done || o_busy) dc++;
        end
        chk("rmid_no_activity", dc, 0);
        chk("rmid_m160", mem[160], 8'd1);
        chk("rmid_m161", mem[161], 8'hEE);
        chk("rmid_m162", mem[162], 8'hEE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
